// File: rtl/iter_mul.sv
// Iterative shift-add multiplier: retires STEP bits of B per cycle on operand
// magnitudes, then applies the sign once at the end. Valid/ready on both sides.
module iter_mul #(
  parameter int A_WIDTH = 32,
  parameter int B_WIDTH = 8,
  parameter int STEP    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [A_WIDTH-1:0]         in_a,
  input  logic [B_WIDTH-1:0]         in_b,
  input  logic                       in_signed,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [A_WIDTH+B_WIDTH-1:0] out_y,
  output logic                       busy
);

  localparam int N  = B_WIDTH / STEP;
  localparam int P  = A_WIDTH + B_WIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [A_WIDTH-1:0] a_q, a_d;
  logic [B_WIDTH-1:0] b_q, b_d;
  logic               neg_q, neg_d;
  logic [P-1:0]       acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [P-1:0]       out_y_q, out_y_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic [A_WIDTH-1:0] a_mag;
  logic [B_WIDTH-1:0] b_mag;
  logic [P-1:0]       pp;
  logic [P-1:0]       sum;
  logic [P-1:0]       final_y;

  // Datapath helpers shared by the next-state logic.
  always_comb begin
    a_mag   = (in_signed && in_a[A_WIDTH-1]) ? -in_a : in_a;
    b_mag   = (in_signed && in_b[B_WIDTH-1]) ? -in_b : in_b;
    pp      = P'(a_q) * P'(b_q[STEP-1:0]);
    pp      = pp << (cnt_q * STEP);
    sum     = acc_q + pp;
    final_y = neg_q ? -sum : sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      neg_q       <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_y_q     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      neg_q       <= neg_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_y_q     <= out_y_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    neg_d       = neg_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_y_d     = out_y_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a_mag;
          b_d     = b_mag;
          neg_d   = in_signed & (in_a[A_WIDTH-1] ^ in_b[B_WIDTH-1]);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = sum;
        b_d   = b_q >> STEP;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          out_y_d     = final_y;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered from the next state so busy tracks the current state exactly.
    busy_d = (state_d != IDLE);
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = out_valid_q;
    out_y     = out_y_q;
    busy      = busy_q;
  end

endmodule

// File: tb/tb_iter_mul.sv
// Scoreboard bench for iter_mul: three instances (STEP=2,1,8) share one
// reference model; instance 0 also runs directed vectors, backpressure and reset.
module tb_iter_mul;

  localparam int NG = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst[NG], in_valid[NG], in_ready[NG], in_signed[NG];
  logic        out_valid[NG], out_ready[NG], busy[NG];
  logic [31:0] in_a[NG];
  logic [7:0]  in_b[NG];
  logic [39:0] out_y[NG];

  logic [39:0] exp_q[NG][$];
  int          acc_cyc[NG];
  logic        ov_prev[NG];
  bit          done[NG];
  int          errors = 0;
  int          checks = 0;

  function automatic int n_of(input int g);
    return (g == 0) ? 4 : (g == 1) ? 8 : 1;
  endfunction

  function automatic logic [39:0] model(input logic [31:0] a, input logic [7:0] b, input logic s);
    logic signed [39:0] sa, sb;
    sa = s ? {{8{a[31]}}, a} : {8'b0, a};
    sb = s ? {{32{b[7]}}, b} : {32'b0, b};
    return sa * sb;
  endfunction

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  generate
    for (genvar g = 0; g < NG; g++) begin : g_dut
      localparam int ST = (g == 0) ? 2 : (g == 1) ? 1 : 8;
      iter_mul #(.A_WIDTH(32), .B_WIDTH(8), .STEP(ST)) u_dut (
        .clk      (clk),
        .rst      (rst[g]),
        .in_valid (in_valid[g]),
        .in_ready (in_ready[g]),
        .in_a     (in_a[g]),
        .in_b     (in_b[g]),
        .in_signed(in_signed[g]),
        .out_valid(out_valid[g]),
        .out_ready(out_ready[g]),
        .out_y    (out_y[g]),
        .busy     (busy[g])
      );

      always @(negedge clk) begin
        if (rst[g] === 1'b0) begin
          if (out_valid[g] && !ov_prev[g])
            check($sformatf("latency[%0d]", g), 40'(cyc - acc_cyc[g]), 40'(8 / ST));
          if (out_valid[g] && out_ready[g]) begin
            if (exp_q[g].size() == 0) begin
              check($sformatf("unexpected_out[%0d]", g), out_y[g], 40'hx);
            end else begin
              check($sformatf("product[%0d]", g), out_y[g], exp_q[g].pop_front());
            end
          end
        end
        ov_prev[g] = out_valid[g];
      end
    end
  endgenerate

  // Present operands until accepted; returns 1ns after the accepting edge.
  task automatic send(input int g, input logic [31:0] a, input logic [7:0] b,
                      input logic s, input logic [39:0] e);
    int   n;
    logic rdy;
    n = 0;
    in_a[g] = a; in_b[g] = b; in_signed[g] = s; in_valid[g] = 1'b1;
    do begin
      @(negedge clk);
      rdy = in_ready[g];
      @(posedge clk);
      n++;
    end while (!rdy && n < 200);
    #1;
    in_valid[g] = 1'b0;
    if (rdy) begin
      exp_q[g].push_back(e);
      acc_cyc[g] = cyc;
    end else begin
      check($sformatf("accept_timeout[%0d]", g), 40'(rdy), 40'd1);
    end
  endtask

  task automatic wait_idle(input int g);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready[g]) break;
    end
    @(posedge clk); #1;
  endtask

  task automatic rand_run(input int g, input int count);
    int          prev;
    logic [31:0] a;
    logic [7:0]  b;
    logic        s;
    prev = 0;
    for (int i = 0; i < count; i++) begin
      case ($urandom_range(0, 5))
        0:       a = 32'h8000_0000;
        1:       a = '1;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       b = 8'h80;
        1:       b = '1;
        default: b = 8'($urandom);
      endcase
      s = 1'($urandom);
      send(g, a, b, s, model(a, b, s));
      if (i > 0)
        check($sformatf("spacing[%0d]", g), 40'(acc_cyc[g] - prev), 40'(n_of(g) + 2));
      prev = acc_cyc[g];
    end
  endtask

  initial begin
    for (int g = 0; g < NG; g++) begin
      rst[g] = 1'b1; in_valid[g] = 1'b0; in_a[g] = '0; in_b[g] = '0;
      in_signed[g] = 1'b0; out_ready[g] = 1'b1; ov_prev[g] = 1'b0; done[g] = 1'b0;
      acc_cyc[g] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", 40'(in_ready[0]), 40'd1);
    check("reset_out_valid", 40'(out_valid[0]), 40'd0);
    check("reset_out_y", out_y[0], 40'd0);
    check("reset_busy", 40'(busy[0]), 40'd0);
    @(posedge clk); #1;
    for (int g = 0; g < NG; g++) rst[g] = 1'b0;

    send(0, 32'hFFFF_FFFF, 8'hFF, 1'b0, 40'hFE_FFFF_FF01);
    send(0, 32'hFFFF_FFFD, 8'h05, 1'b1, 40'hFF_FFFF_FFF1);
    send(0, 32'hFFFF_FFFD, 8'h05, 1'b0, 40'h04_FFFF_FFF1);
    send(0, 32'h8000_0000, 8'h80, 1'b1, 40'h40_0000_0000);
    send(0, 32'h8000_0000, 8'hFF, 1'b1, 40'h00_8000_0000);
    send(0, 32'h8000_0000, 8'hFF, 1'b0, 40'h7F_8000_0000);

    // Backpressure: hold the result, offer a competing operand that must be ignored.
    wait_idle(0);
    out_ready[0] = 1'b0;
    send(0, 32'h1234_5678, 8'h10, 1'b0, 40'h01_2345_6780);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid[0]) break;
    end
    @(posedge clk); #1;
    in_valid[0] = 1'b1; in_a[0] = 32'd5; in_b[0] = 8'd5; in_signed[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_out_valid", 40'(out_valid[0]), 40'd1);
      check("bp_out_y", out_y[0], 40'h01_2345_6780);
      check("bp_in_ready", 40'(in_ready[0]), 40'd0);
    end
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_in_ready", 40'(in_ready[0]), 40'd1);
    check("bp_release_out_valid", 40'(out_valid[0]), 40'd0);
    check("bp_release_out_y_kept", out_y[0], 40'h01_2345_6780);
    @(posedge clk); #1;

    // Abort during the second BUSY cycle.
    send(0, 32'd3, 8'd5, 1'b0, 40'd15);
    @(posedge clk); #1;
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 40'(in_ready[0]), 40'd1);
    check("abort_out_valid", 40'(out_valid[0]), 40'd0);
    check("abort_out_y", out_y[0], 40'd0);
    check("abort_busy", 40'(busy[0]), 40'd0);
    exp_q[0].delete();
    @(posedge clk); #1;
    send(0, 32'd7, 8'd9, 1'b0, 40'd63);

    wait_idle(0);
    rand_run(0, 1000);
    done[0] = 1'b1;

    for (int n = 0; n < 30000 && !(done[1] && done[2]); n++) @(posedge clk);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0) break;
    end
    for (int g = 0; g < NG; g++)
      check($sformatf("drain[%0d]", g), 40'(exp_q[g].size()), 40'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    repeat (5) @(posedge clk); #1;
    rand_run(1, 1000);
    done[1] = 1'b1;
  end

  initial begin
    repeat (5) @(posedge clk); #1;
    rand_run(2, 1000);
    done[2] = 1'b1;
  end

endmodule
